sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 32-bit SRAM controller.
- Port 0 carries MEM-stage data accesses. Port 1 carries a secondary master (instruction fetch or loader).
- Latches one request at a time and pulses the controller enable for a single cycle. Holds address and data stable until the controller's ready returns, then issues a one-cycle ack with the read data to the winning port.

Parameters:
- MAX_WAIT, 15: watchdog limit, in cycles, spent in WAIT before the transfer is aborted. Width 4 bits.
- DATA_W, 32: data and address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  port 0 request; held high until req0_ack
- req0_we  in  1  port 0: 1 = write, 0 = read
- req0_addr  in  32  port 0 byte address
- req0_wdata  in  32  port 0 write data
- req0_ack  out  1  port 0 completion pulse
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ack  as port 0, for port 1
- rdata  out  32  read data, shared by both ports; valid while either ack is high
- mem_read_en  out  1  to controller read_enable
- mem_write_en  out  1  to controller write_enable
- mem_addr  out  32  to controller address
- mem_wdata  out  32  to controller write_data
- mem_rdata  in  32  from controller read_data
- mem_ready  in  1  from controller ready
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0, all outputs 0, internal address/data/we latches 0, watchdog counter 0.
- Sequential logic is posedge clk; reset is negedge rst.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, request selection:
  - If any valid is high, select the winner, latch its addr, wdata, we and port id, and go to ISSUE.
  - Round-robin: with both valid, the port equal to rr_ptr wins. With one valid, that port wins.
- ISSUE (exactly 1 cycle):
  - mem_read_en = ~we_l; mem_write_en = we_l. Go to WAIT.
- WAIT:
  - Enables are 0; watchdog counter increments each cycle.
  - On mem_ready=1: capture rdata <= mem_rdata (reads only; writes leave rdata unchanged) and go to RESP.
  - On watchdog == MAX_WAIT with mem_ready=0: set timeout_err=1, rdata <= 0, go to RESP.
- RESP (1 cycle):
  - reqN_ack=1 for the latched port only.
  - rr_ptr <= ~granted port; watchdog counter cleared. Go to IDLE.
- mem_addr and mem_wdata come from the latches in every state. They are constant from ISSUE through RESP.
- Enables are never high outside ISSUE, so the controller cannot retrigger.
- Latency: valid sampled in IDLE at cycle 0 -> ISSUE at 1 -> WAIT at 2..8 (controller counter 0..6, mem_ready high at 8) -> ack at 9. Request-to-ack is 9 cycles.
- Next request: earliest sampling is the cycle after ack (IDLE). A requester keeping valid high with new fields is served then. Back-to-back throughput is one access per 10 cycles.
- Requester rule: a requester must not change addr/we/wdata while valid is high before ack. Changes after the latch cycle are ignored.
- A valid dropped early is not cancelled: the latched transfer completes and ack still pulses.
- Both ports valid every cycle: grants alternate 0,1,0,1.
- Reset mid-transfer: immediate return to IDLE, enables low, no ack. The controller is reset by the same net.
- timeout_err is cleared only by reset.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both ports are valid; rr_ptr is not implemented.
- Undefined: round-robin as above.
- Latency and every other behaviour are identical in both builds.

Test Plan:
- Port 0 read, addr 0x400, controller model returns 0x12345678: mem_read_en high exactly at cycle 1, req0_ack at cycle 9, rdata=0x12345678, req1_ack never high.
- Port 1 write, addr 0x408, data 0xA5A5A5A5: mem_write_en single pulse; mem_addr=0x408 and mem_wdata=0xA5A5A5A5 stable cycles 1..9; req1_ack at cycle 9; rdata unchanged.
- Both valid continuously, 4 transfers, default build: ack order 0,1,0,1, 10 cycles apart. Built with ARB_FIXED_PRIO_EN: ack order 0,0,0,0.
- Controller model holds mem_ready=0 forever: after MAX_WAIT cycles in WAIT, timeout_err=1, ack pulses with rdata=0, state returns to IDLE; timeout_err stays 1 until rst=0.
- rst pulled low during WAIT of a port 0 read: all outputs 0 asynchronously, no ack. After release, a new port 1 read completes normally in 9 cycles.
- req0_addr changed at cycle 3 while valid is high: mem_addr keeps the originally latched value through cycle 9.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and sequencer in front of the 32-bit SRAM controller.
// Port 0 carries MEM-stage data accesses, port 1 a secondary master (fetch or loader).
// One request is latched at a time. The controller enable pulses for a single cycle.
// Address and data are held until ready returns, then a one-cycle ack carries rdata.
// Build option: define ARB_FIXED_PRIO_EN to make port 0 win every tie (no round-robin
// pointer). Leave it undefined for round-robin arbitration.
module sram_arbiter #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [DATA_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ack,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [DATA_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned WdW = 4;
    localparam logic [WdW-1:0] MaxWaitC = WdW'(MAX_WAIT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              port_q, port_d;
    logic              timeout_q, timeout_d;
    logic [WdW-1:0]    wd_q, wd_d;
    logic              grant_port;

`ifdef ARB_FIXED_PRIO_EN
    // Port 0 wins any tie; port 1 is chosen only when it is the sole requester.
    assign grant_port = ~req0_valid;
`else
    logic rr_ptr_q, rr_ptr_d;

    // On a tie the port equal to rr_ptr wins; otherwise the only requester wins.
    assign grant_port = (req0_valid && req1_valid) ? rr_ptr_q : ~req0_valid;

    // Pointer moves to the port that was not just served.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == StResp) begin
            rr_ptr_d = ~port_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Sequencer: latch winner, issue one enable pulse, wait for ready or watchdog, ack.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        we_d      = we_q;
        port_d    = port_q;
        timeout_d = timeout_q;
        wd_d      = wd_q;
        unique case (state_q)
            StIdle: begin
                if (req0_valid || req1_valid) begin
                    port_d  = grant_port;
                    addr_d  = grant_port ? req1_addr  : req0_addr;
                    wdata_d = grant_port ? req1_wdata : req0_wdata;
                    we_d    = grant_port ? req1_we    : req0_we;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                wd_d = wd_q + 1'b1;
                if (mem_ready) begin
                    // Writes leave the shared read data untouched.
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = StResp;
                end else if (wd_q == MaxWaitC) begin
                    timeout_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = StResp;
                end
            end
            StResp: begin
                wd_d    = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and latch registers; reset aborts any transfer without an ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            we_q      <= 1'b0;
            port_q    <= 1'b0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            we_q      <= we_d;
            port_q    <= port_d;
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
        end
    end

    // Enables only in ISSUE so the controller never retriggers; ack only in RESP.
    always_comb begin
        mem_read_en  = (state_q == StIssue) && !we_q;
        mem_write_en = (state_q == StIssue) && we_q;
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;
        req0_ack     = (state_q == StResp) && !port_q;
        req1_ack     = (state_q == StResp) && port_q;
        rdata        = rdata_q;
        busy         = (state_q != StIdle);
        timeout_err  = timeout_q;
    end

endmodule
